instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 19 +
 rtl/word_assembler.sv | 46 ++++
 rtl/instr_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader.
// Holds the loader FSM state encoding and the framing constants of the
// serial load protocol: a two-byte little-endian word count followed by
// four-byte little-endian instruction words.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted serial bytes into 32-bit little-endian words.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : discard any partial word (session start)
//   shift_en     : byte_in is accepted this cycle
//   byte_in      : serial byte
//   word_next    : word including the byte being accepted this cycle
//   word_full    : the byte accepted this cycle completes a word
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [1:0]  byte_cnt;
  logic [31:0] shreg;
  logic        unused_lsb;

  // New bytes enter at the top, so after four shifts the first byte sits
  // in bits 7:0. word_next exposes the completed word on the same edge the
  // last byte arrives, letting the loader register it without a bubble.
  assign word_next  = {byte_in, shreg[31:8]};
  assign word_full  = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  // The oldest byte falls off the bottom of the shift and is never read.
  assign unused_lsb = ^shreg[7:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
    end else if (shift_en) begin
      shreg    <= word_next;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Serial instruction loader: receives a length-prefixed byte stream,
// writes the assembled 32-bit words into instruction memory and then
// releases the processor (cpu_run) or flags an oversized image (load_error).
// Ports:
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   start                : one-cycle pulse beginning a load session
//   byte_in, byte_valid  : serial source; a byte moves when byte_ready is high
//   byte_ready           : loader will accept a byte this cycle
//   mem_we, mem_addr,
//   mem_wdata            : one-cycle write of a word at byte address index*4
//   cpu_run              : high after a successful load
//   load_error           : high after a rejected load
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_run,
  output logic        load_error
);

  localparam logic [16:0] MAX_LEN = 17'(MEM_WORDS);

  state_t      state;
  logic [15:0] len;
  logic [15:0] index;
  logic [7:0]  len_lo;
  logic        hdr_cnt;
  logic [15:0] len_rx;
  logic        xfer;
  logic        asm_clear;
  logic        shift_en;
  logic        word_full;
  logic [31:0] word_next;

  assign xfer      = byte_valid && byte_ready;
  assign len_rx    = {byte_in, len_lo};
  assign asm_clear = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign shift_en  = xfer && (state == ST_DATA);

  word_assembler u_word_assembler (
    .clock     (clock),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (shift_en),
    .byte_in   (byte_in),
    .word_next (word_next),
    .word_full (word_full)
  );

  // byte_ready is registered alongside each transition so it always
  // reflects the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      cpu_run    <= 1'b0;
      load_error <= 1'b0;
      len        <= 16'd0;
      index      <= 16'd0;
      len_lo     <= 8'd0;
      hdr_cnt    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_HDR;
            byte_ready <= 1'b1;
            index      <= 16'd0;
            hdr_cnt    <= 1'b0;
            cpu_run    <= 1'b0;
            load_error <= 1'b0;
          end else begin
            cpu_run    <= (state == ST_DONE);
            load_error <= (state == ST_ERR);
          end
        end
        ST_HDR: begin
          if (xfer) begin
            if (hdr_cnt == 1'(HDR_BYTES - 1)) begin
              len     <= len_rx;
              hdr_cnt <= 1'b0;
              if (len_rx == 16'd0) begin
                state      <= ST_DONE;
                byte_ready <= 1'b0;
              end else if ({1'b0, len_rx} > MAX_LEN) begin
                state      <= ST_ERR;
                byte_ready <= 1'b0;
              end else begin
                state <= ST_DATA;
              end
            end else begin
              len_lo  <= byte_in;
              hdr_cnt <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          // Strobe and data are registered on the last byte's edge so the
          // write lands exactly one cycle later, during WRITE.
          if (word_full) begin
            state      <= ST_WRITE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b1;
            mem_addr   <= {14'd0, index, 2'b00};
            mem_wdata  <= word_next;
          end
        end
        ST_WRITE: begin
          // index < len here, so the increment never wraps past 16 bits.
          index <= index + 16'd1;
          if (index + 16'd1 == len) begin
            state <= ST_DONE;
          end else begin
            state      <= ST_DATA;
            byte_ready <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
